// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared definitions for the dual-port RAM round-robin arbiter.
//   tag_t        : per-port return-path tag {valid, read, requester index}
//   rr_next      : wrap-around increment used for the rotate-scan pointer
//   addr_conflict: same-cycle hazard between the two picked requests
package dpram_rr_arbiter_pkg;

    // Index field is sized for the largest supported requester count (8).
    localparam int TAG_IDXW = 3;

    typedef struct packed {
        logic                valid;
        logic                rd;
        logic [TAG_IDXW-1:0] idx;
    } tag_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Two accesses to one address are only safe when both are reads.
    function automatic logic addr_conflict(input logic same_addr,
                                           input logic wr_x,
                                           input logic wr_y);
        return same_addr & (wr_x | wr_y);
    endfunction

    function automatic tag_t make_tag(input logic                valid,
                                      input logic                rd,
                                      input logic [TAG_IDXW-1:0] idx);
        tag_t t;
        t.valid = valid;
        t.rd    = rd;
        t.idx   = idx;
        return t;
    endfunction

endpackage

// File: rtl/dpram_rr_arbiter_pick.sv
// Combinational rotate-scan picker.
//   mask  : candidate requesters
//   start : index the scan begins at (wraps modulo NREQ)
//   found : at least one mask bit set
//   idx   : first set index at or after start, wrapping
module dpram_arb_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] mask,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    // First pass covers start..NREQ-1, second pass the wrapped 0..start-1.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && mask[i] && (i >= int'(start))) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && mask[i]) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NREQ requesters.
//   req/wr/addr/wdata : requester side, held until gnt
//   gnt               : combinational accept pulse, up to two per cycle
//   rvalid/rdata      : tagged read return, two cycles after gnt
//   ram_*             : registered RAM port A/B controls, ram_dout_* registered RAM data
module dpram_rr_arbiter
    import dpram_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ADDR  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       wr,
    input  logic [NREQ*ADDR-1:0]  addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [NREQ*WIDTH-1:0] rdata,
    output logic                  ram_ena,
    output logic                  ram_enb,
    output logic                  ram_wra,
    output logic                  ram_wrb,
    output logic [ADDR-1:0]       ram_addr_a,
    output logic [ADDR-1:0]       ram_addr_b,
    output logic [WIDTH-1:0]      ram_din_a,
    output logic [WIDTH-1:0]      ram_din_b,
    input  logic [WIDTH-1:0]      ram_dout_a,
    input  logic [WIDTH-1:0]      ram_dout_b
);

    localparam int IDXW = $clog2(NREQ);

    logic [IDXW-1:0]       ptr;
    logic                  a_found, b_found;
    logic [IDXW-1:0]       a_idx, b_idx, b_start;
    logic [NREQ-1:0]       b_mask;
    logic [ADDR-1:0]       a_addr, b_addr;
    logic [WIDTH-1:0]      a_din, b_din;
    logic                  a_wr, b_wr;
    tag_t                  s1a, s1b, s2a, s2b;
    logic [NREQ*WIDTH-1:0] rdata_q;

    dpram_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_a (
        .mask  (req),
        .start (ptr),
        .found (a_found),
        .idx   (a_idx)
    );

    always_comb begin
        a_addr = '0;
        a_din  = '0;
        a_wr   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (a_idx == IDXW'(i)) begin
                a_addr = addr[i*ADDR +: ADDR];
                a_din  = wdata[i*WIDTH +: WIDTH];
                a_wr   = wr[i];
            end
        end
        // B candidates: everything still requesting except A and A's hazards.
        b_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            b_mask[i] = req[i] && (a_idx != IDXW'(i)) &&
                        !addr_conflict(addr[i*ADDR +: ADDR] == a_addr, a_wr, wr[i]);
        end
        b_start = IDXW'(rr_next(int'(a_idx), NREQ));
    end

    dpram_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick_b (
        .mask  (b_mask),
        .start (b_start),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        b_addr = '0;
        b_din  = '0;
        b_wr   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (b_idx == IDXW'(i)) begin
                b_addr = addr[i*ADDR +: ADDR];
                b_din  = wdata[i*WIDTH +: WIDTH];
                b_wr   = wr[i];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                gnt[i] = (a_found && (a_idx == IDXW'(i))) ||
                         (b_found && (b_idx == IDXW'(i)));
            end
        end
    end

    // Stage-2 tags line up with the RAM's registered read data, so the
    // return is steered straight from ram_dout; rdata_q holds idle slices.
    always_comb begin
        rvalid = '0;
        rdata  = rst ? '0 : rdata_q;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s2a.valid && s2a.rd && (s2a.idx == TAG_IDXW'(i))) begin
                    rvalid[i]                = 1'b1;
                    rdata[i*WIDTH +: WIDTH]  = ram_dout_a;
                end else if (s2b.valid && s2b.rd && (s2b.idx == TAG_IDXW'(i))) begin
                    rvalid[i]                = 1'b1;
                    rdata[i*WIDTH +: WIDTH]  = ram_dout_b;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            ram_ena    <= 1'b0;
            ram_enb    <= 1'b0;
            ram_wra    <= 1'b0;
            ram_wrb    <= 1'b0;
            ram_addr_a <= '0;
            ram_addr_b <= '0;
            ram_din_a  <= '0;
            ram_din_b  <= '0;
            s1a        <= '0;
            s1b        <= '0;
            s2a        <= '0;
            s2b        <= '0;
            rdata_q    <= '0;
        end else begin
            if (b_found)
                ptr <= IDXW'(rr_next(int'(b_idx), NREQ));
            else if (a_found)
                ptr <= IDXW'(rr_next(int'(a_idx), NREQ));

            ram_ena <= a_found;
            ram_wra <= a_found & a_wr;
            ram_enb <= b_found;
            ram_wrb <= b_found & b_wr;
            if (a_found) begin
                ram_addr_a <= a_addr;
                ram_din_a  <= a_din;
            end
            if (b_found) begin
                ram_addr_b <= b_addr;
                ram_din_b  <= b_din;
            end

            s1a     <= make_tag(a_found, !a_wr, TAG_IDXW'(a_idx));
            s1b     <= make_tag(b_found, !b_wr, TAG_IDXW'(b_idx));
            s2a     <= s1a;
            s2b     <= s1b;
            rdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
module tb_dpram_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int ADDR  = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       wr = '0;
    logic [NREQ*ADDR-1:0]  addr = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt, rvalid;
    logic [NREQ*WIDTH-1:0] rdata;
    logic                  ram_ena, ram_enb, ram_wra, ram_wrb;
    logic [ADDR-1:0]       ram_addr_a, ram_addr_b;
    logic [WIDTH-1:0]      ram_din_a, ram_din_b;
    logic [WIDTH-1:0]      ram_dout_a, ram_dout_b;

    int n_cmp = 0;
    int n_bad = 0;

    dpram_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ram_ena    (ram_ena),
        .ram_enb    (ram_enb),
        .ram_wra    (ram_wra),
        .ram_wrb    (ram_wrb),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM model with registered read data; contents preset to i*7+3 on reset.
    logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1<<ADDR); i++) mem[i] <= 8'(i*7 + 3);
        end else begin
            if (ram_ena && ram_wra) mem[ram_addr_a] <= ram_din_a;
            if (ram_enb && ram_wrb) mem[ram_addr_b] <= ram_din_b;
        end
        if (ram_ena && !ram_wra) ram_dout_a <= mem[ram_addr_a];
        if (ram_enb && !ram_wrb) ram_dout_b <= mem[ram_addr_b];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit w, input int a, input int d);
        req[i]                  = 1'b1;
        wr[i]                   = w;
        addr[i*ADDR +: ADDR]    = 6'(a);
        wdata[i*WIDTH +: WIDTH] = 8'(d);
    endtask

    task automatic do_reset();
        cyc();
        req = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            #2;
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_gnt cyc %0d: got %b expected 0000", c, gnt);
            end
            n_cmp++;
            if ({ram_ena, ram_enb, rvalid} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_en_rvalid cyc %0d: got %b expected 000000", c, {ram_ena, ram_enb, rvalid});
            end
        end
        n_cmp++;
        if (rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_write_read();
        cyc();
        set_req(0, 1'b1, 5, 8'hA5);
        #2;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL wr_gnt: got %b expected 0001", gnt);
        end
        cyc();
        set_req(0, 1'b0, 5, 0);
        #2;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL rd_gnt: got %b expected 0001", gnt);
        end
        cyc();
        req = '0;
        #2;
        n_cmp++;
        if (rvalid !== 4'b0000) begin
            n_bad++;
            $display("FAIL rd_early: got %b expected 0000", rvalid);
        end
        cyc();
        #2;
        n_cmp++;
        if (rvalid !== 4'b0001) begin
            n_bad++;
            $display("FAIL rd_rvalid: got %b expected 0001", rvalid);
        end
        n_cmp++;
        if (rdata[7:0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL rd_data: got %h expected a5", rdata[7:0]);
        end
    endtask

    task automatic test_dual_grant();
        do_reset();
        cyc();
        set_req(0, 1'b0, 1, 0);
        set_req(2, 1'b0, 2, 0);
        #2;
        n_cmp++;
        if (gnt !== 4'b0101) begin
            n_bad++;
            $display("FAIL dual_gnt: got %b expected 0101", gnt);
        end
        cyc();
        req = '0;
        #2;
        n_cmp++;
        if ({ram_ena, ram_enb, ram_wra, ram_wrb, ram_addr_a, ram_addr_b} !== {4'b1100, 6'd1, 6'd2}) begin
            n_bad++;
            $display("FAIL dual_ports: got en/wr %b addr %0d/%0d expected 1100 1/2",
                     {ram_ena, ram_enb, ram_wra, ram_wrb}, ram_addr_a, ram_addr_b);
        end
        cyc();
        #2;
        n_cmp++;
        if (rvalid !== 4'b0101) begin
            n_bad++;
            $display("FAIL dual_rvalid: got %b expected 0101", rvalid);
        end
        n_cmp++;
        if ({rdata[23:16], rdata[7:0]} !== 16'h110A) begin
            n_bad++;
            $display("FAIL dual_rdata: got %h expected 110a", {rdata[23:16], rdata[7:0]});
        end
        // ptr should now be 3: with all four reading, A=3 and B wraps to 0.
        cyc();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 20 + i, 0);
        #2;
        n_cmp++;
        if (rdata[7:0] !== 8'h0A || rvalid !== 4'b0000) begin
            n_bad++;
            $display("FAIL dual_hold: got rdata0 %h rvalid %b expected 0a 0000", rdata[7:0], rvalid);
        end
        n_cmp++;
        if (gnt !== 4'b1001) begin
            n_bad++;
            $display("FAIL ptr3_gnt: got %b expected 1001", gnt);
        end
        cyc();
        req = '0;
        cyc();
        #2;
        n_cmp++;
        if (rvalid !== 4'b1001) begin
            n_bad++;
            $display("FAIL ptr3_rvalid: got %b expected 1001", rvalid);
        end
    endtask

    task automatic test_conflict();
        // ptr is 1 here (last grant was B=0).
        cyc();
        set_req(1, 1'b1, 9, 8'h5C);
        set_req(2, 1'b0, 9, 0);
        #2;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL conf_gnt1: got %b expected 0010", gnt);
        end
        cyc();
        req[1] = 1'b0;
        #2;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL conf_gnt2: got %b expected 0100", gnt);
        end
        cyc();
        req = '0;
        cyc();
        #2;
        n_cmp++;
        if (rvalid !== 4'b0100) begin
            n_bad++;
            $display("FAIL conf_rvalid: got %b expected 0100", rvalid);
        end
        n_cmp++;
        if (rdata[23:16] !== 8'h5C) begin
            n_bad++;
            $display("FAIL conf_rdata: got %h expected 5c", rdata[23:16]);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_g;
        do_reset();
        cyc();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 30 + i, 0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            #2;
            exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            n_cmp++;
            if (gnt !== exp_g) begin
                n_bad++;
                $display("FAIL fair_gnt cyc %0d: got %b expected %b", c, gnt, exp_g);
            end
            if (c >= 2) begin
                n_cmp++;
                if (rvalid !== exp_g) begin
                    n_bad++;
                    $display("FAIL fair_rvalid cyc %0d: got %b expected %b", c, rvalid, exp_g);
                end
                n_cmp++;
                if (c % 2 == 0 && rdata[15:0] !== 16'hDCD5) begin
                    n_bad++;
                    $display("FAIL fair_rdata01 cyc %0d: got %h expected dcd5", c, rdata[15:0]);
                end else if (c % 2 == 1 && rdata[31:16] !== 16'hEAE3) begin
                    n_bad++;
                    $display("FAIL fair_rdata23 cyc %0d: got %h expected eae3", c, rdata[31:16]);
                end
            end
        end
        cyc();
        req = '0;
        cyc();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cyc();
        set_req(1, 1'b0, 40, 0);
        #2;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL mid_gnt: got %b expected 0010", gnt);
        end
        cyc();
        req = '0;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({gnt, rvalid} !== 8'b0) begin
            n_bad++;
            $display("FAIL mid_in_rst: got gnt %b rvalid %b expected 0000 0000", gnt, rvalid);
        end
        cyc();
        rst = 1'b0;
        #2;
        n_cmp++;
        if (rvalid !== 4'b0000 || rdata !== '0) begin
            n_bad++;
            $display("FAIL mid_dropped: got rvalid %b rdata %h expected 0000 0", rvalid, rdata);
        end
        // Two writes to one address: only the one first in scan order from ptr wins.
        cyc();
        set_req(1, 1'b1, 50, 8'h11);
        set_req(2, 1'b1, 50, 8'h22);
        #2;
        n_cmp++;
        if (rvalid !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_late: got rvalid %b expected 0000", rvalid);
        end
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL mid_ptr0: got %b expected 0010", gnt);
        end
        cyc();
        req[1] = 1'b0;
        #2;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL mid_retry: got %b expected 0100", gnt);
        end
        cyc();
        req = '0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dual_grant();
        test_conflict();
        test_fairness();
        test_reset_midflight();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
